// File: rtl/mprjram_arbiter.sv
// Arbiter for the single-port mprjram BRAM: Wishbone slave path vs. accelerator DMA port.
// Define ARB_FIXED_PRIO_EN to give Wishbone fixed priority in IDLE; otherwise round-robin.
module mprjram_arbiter #(
    parameter int         ADDR_W    = 10,
    parameter int         RD_LAT    = 10,
    parameter int         MAX_BURST = 16,
    parameter logic [7:0] BASE_HI   = 8'h38
) (
    input  logic              wb_clk_i,
    input  logic              wb_rstn_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wdata,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_wdata,
    input  logic [31:0]       bram_rdata
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, WB_WAIT, DMA_BURST} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_WB, TAG_DMA} tag_t;

    state_t           state;
    tag_t             tag_pipe [RD_LAT];
    tag_t             tag_in, tag_ret;
    logic [CNT_W-1:0] beat_cnt, cnt_next;
    logic             wb_abort, wb_busy, wb_hit, wb_first, wb_issue, wb_ret;
    logic             dma_issue, dma_end;
    logic             unused_adr;

    assign unused_adr = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

    // The ack cycle counts as busy: the master still holds stb while it sees the ack.
    assign wb_busy = (state == WB_WAIT) || wbs_ack_o;
    assign wb_hit  = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:24] == BASE_HI) && !wb_busy;

`ifdef ARB_FIXED_PRIO_EN
    assign wb_first = 1'b1;
`else
    logic last_dma;
    assign wb_first = !dma_req || last_dma;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i)    last_dma <= 1'b1;
        else if (wb_issue) last_dma <= 1'b0;
        else if (dma_end)  last_dma <= 1'b1;
    end
`endif

    assign wb_issue  = wb_rstn_i && (state == IDLE) && wb_hit && wb_first;
    assign dma_issue = wb_rstn_i && dma_req &&
                       (((state == IDLE) && !wb_issue) || (state == DMA_BURST));
    assign dma_gnt   = dma_issue;
    assign cnt_next  = (state == DMA_BURST) ? beat_cnt + 1'b1 : CNT_W'(1);
    assign dma_end   = (dma_issue && (dma_last || (cnt_next == BURST_MAX))) ||
                       ((state == DMA_BURST) && !dma_req);

    assign tag_in  = (wb_issue && !wbs_we_i) ? TAG_WB :
                     (dma_issue && !dma_we)  ? TAG_DMA : TAG_NONE;
    assign tag_ret = tag_pipe[RD_LAT-1];
    assign wb_ret  = (tag_ret == TAG_WB) && !wb_abort && wbs_cyc_i;

    assign bram_en = wb_issue || dma_issue;

    always_comb begin
        bram_addr  = '0;
        bram_wdata = '0;
        bram_we    = 4'h0;
        if (wb_issue) begin
            bram_addr  = wbs_adr_i[ADDR_W+1:2];
            bram_wdata = wbs_dat_i;
            bram_we    = wbs_we_i ? wbs_sel_i : 4'h0;
        end else if (dma_issue) begin
            bram_addr  = dma_addr;
            bram_wdata = dma_wdata;
            bram_we    = dma_we ? 4'hF : 4'h0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            wb_abort   <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

            // Writes ack the cycle after issue; reads ack when their tag emerges.
            wbs_ack_o <= (wb_issue && wbs_we_i) || wb_ret;
            if (wb_ret) wbs_dat_o <= bram_rdata;
            dma_rvalid <= (tag_ret == TAG_DMA);
            if (tag_ret == TAG_DMA) dma_rdata <= bram_rdata;

            if (dma_issue) beat_cnt <= cnt_next;

            case (state)
                IDLE: begin
                    if (wb_issue && !wbs_we_i) begin
                        state    <= WB_WAIT;
                        wb_abort <= 1'b0;
                    end else if (dma_issue && !dma_end) begin
                        state <= DMA_BURST;
                    end
                end
                WB_WAIT: begin
                    if (!wbs_cyc_i) wb_abort <= 1'b1;
                    if (tag_ret == TAG_WB) state <= IDLE;
                end
                DMA_BURST: if (dma_end) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mprjram_arbiter.sv
// Directed + randomized bench for mprjram_arbiter with a behavioural BRAM and a reference memory.
module tb_mprjram_arbiter;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 10;

    logic              clk = 1'b0;
    logic              rstn;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic              wbs_ack_o;
    logic              dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
    logic [ADDR_W-1:0] dma_addr, bram_addr;
    logic [31:0]       dma_wdata, dma_rdata, bram_wdata, bram_rdata;
    logic              bram_en;
    logic [3:0]        bram_we;

    mprjram_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_BURST(16), .BASE_HI(8'h38)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: one-cycle bulk preload, byte writes, RD_LAT-cycle read pipe, junk when idle.
    logic [31:0] mem    [1024];
    logic [31:0] ld_img [1024];
    logic [31:0] rpipe  [RD_LAT];
    logic        ld_en = 1'b0;
    always @(posedge clk) begin
        if (ld_en) for (int i = 0; i < 1024; i++) mem[i] <= ld_img[i];
        if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            rpipe[0] <= mem[bram_addr];
        end else begin
            rpipe[0] <= $urandom;
        end
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bram_rdata = rpipe[RD_LAT-1];

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct { int c; logic [31:0] d; } ev_t;
    ev_t wb_q[$];
    ev_t dma_q[$];
    always @(negedge clk) begin
        if (wbs_ack_o === 1'b1)  wb_q.push_back('{cyc_n, wbs_dat_o});
        if (dma_rvalid === 1'b1) dma_q.push_back('{cyc_n, dma_rdata});
    end

    logic [31:0] ref_mem [1024];
    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic wb_xfer(input string tag, input logic [31:0] adr, input bit we, input logic [3:0] sel,
                           input logic [31:0] dat, output int ic);
        bit got = 0;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
        settle();
        ic = cyc_n;
        check({tag, ".en"}, 32'(bram_en), 32'd1);
        check({tag, ".addr"}, 32'(bram_addr), 32'(adr[11:2]));
        check({tag, ".we"}, 32'(bram_we), we ? 32'(sel) : 32'd0);
        for (int k = 0; k < 40; k++) begin
            tick(); settle();
            if (wbs_ack_o) begin got = 1; break; end
        end
        check({tag, ".ack_seen"}, 32'(got), 32'd1);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        tick();
    endtask

    task automatic expect_wb(input string tag, input int c, input logic [31:0] d);
        check({tag, ".acks"}, 32'(wb_q.size()), 32'd1);
        if (wb_q.size() > 0) begin
            check({tag, ".ack_cyc"}, 32'(wb_q[0].c), 32'(c));
            check({tag, ".dat"}, wb_q[0].d, d);
        end
        wb_q.delete();
    endtask

    task automatic dma_burst(input string tag, input logic [9:0] start, input int n, input bit we, output int fc);
        fc = 0;
        for (int k = 0; k < n; k++) begin
            logic [31:0] d;
            d = $urandom;
            dma_req = 1; dma_we = we; dma_addr = 10'(start + k); dma_wdata = d; dma_last = (k == n - 1);
            settle();
            if (k == 0) fc = cyc_n;
            check({tag, ".gnt"}, 32'(dma_gnt), 32'd1);
            check({tag, ".addr"}, 32'(bram_addr), 32'(10'(start + k)));
            check({tag, ".we"}, 32'(bram_we), we ? 32'hF : 32'h0);
            if (we) ref_mem[10'(start + k)] = d;
            tick();
        end
        dma_req = 0; dma_we = 0; dma_last = 0;
    endtask

    task automatic expect_dma(input string tag, input logic [9:0] start, input int n, input int fc);
        check({tag, ".beats"}, 32'(dma_q.size()), 32'(n));
        if (dma_q.size() == n)
            for (int k = 0; k < n; k++) begin
                check({tag, ".rv_cyc"}, 32'(dma_q[k].c), 32'(fc + RD_LAT + 1 + k));
                check({tag, ".rdata"}, dma_q[k].d, ref_mem[10'(start + k)]);
            end
        dma_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ack"}, 32'(wbs_ack_o), 32'd0);
        check({tag, ".wdat"}, wbs_dat_o, 32'd0);
        check({tag, ".gnt"}, 32'(dma_gnt), 32'd0);
        check({tag, ".rvalid"}, 32'(dma_rvalid), 32'd0);
        check({tag, ".rdata"}, dma_rdata, 32'd0);
        check({tag, ".en"}, 32'(bram_en), 32'd0);
        check({tag, ".bwe"}, 32'(bram_we), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal;
    end

    logic [9:0]  a, b, x, y;
    logic [31:0] d, d2;
    logic [3:0]  s;
    int          ic, fc, s_c, wb_ic, grants, nen;
    bit          wb_done, wb_on;
    int          gq[$];

    initial begin
        rstn = 0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_last = 0;
        for (int i = 0; i < 1024; i++) ld_img[i] = $urandom;
        ld_img[4] = 32'hDEADBEEF;
        for (int i = 0; i < 1024; i++) ref_mem[i] = ld_img[i];
        ld_en = 1;
        tick();
        ld_en = 0;
        tick(); settle();
        check_reset_outputs("reset");
        rstn = 1;
        tick();

        // Plain WB read, then a byte-masked write and read-back.
        wb_q.delete();
        wb_xfer("wb_rd4", 32'h3800_0010, 0, 4'hF, 32'h0, ic);
        expect_wb("wb_rd4", ic + RD_LAT + 1, 32'hDEADBEEF);
        wb_xfer("wb_wr2", 32'h3800_0008, 1, 4'b0011, 32'h1234_5678, ic);
        ref_mem[2] = merge(ref_mem[2], 32'h1234_5678, 4'b0011);
        expect_wb("wb_wr2", ic + 1, wbs_dat_o);
        wb_xfer("wb_rd2", 32'h3800_0008, 0, 4'hF, 32'h0, ic);
        expect_wb("wb_rd2", ic + RD_LAT + 1, ref_mem[2]);

        // A request outside the BASE_HI window is never served.
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0010;
        nen = 0;
        for (int k = 0; k < 15; k++) begin
            settle();
            if (bram_en) nen++;
            tick();
        end
        wbs_cyc_i = 0; wbs_stb_i = 0;
        tick();
        check("miss.en_cycles", 32'(nen), 32'd0);
        check("miss.acks", 32'(wb_q.size()), 32'd0);
        wb_q.delete();

        // 4-beat DMA read burst.
        dma_q.delete();
        dma_burst("dma4", 10'h100, 4, 0, fc);
        wait_ticks(RD_LAT + 3);
        expect_dma("dma4", 10'h100, 4, fc);

        // Randomized cross-traffic: WB writes read by DMA and DMA writes read by WB.
        for (int it = 0; it < 4; it++) begin
            a = 10'($urandom_range(0, 1023));
            s = 4'($urandom_range(1, 15));
            d = $urandom;
            wb_xfer("rnd.wbwr", {20'h38000, a, 2'b00}, 1, s, d, ic);
            ref_mem[a] = merge(ref_mem[a], d, s);
            wb_q.delete();
            dma_burst("rnd.dmard", a, 1, 0, fc);
            wait_ticks(RD_LAT + 3);
            expect_dma("rnd.dmard", a, 1, fc);
            b = 10'($urandom_range(0, 1023));
            dma_burst("rnd.dmawr", b, 1, 1, fc);
            wb_xfer("rnd.wbrd", {20'h38000, b, 2'b00}, 0, 4'hF, 32'h0, ic);
            expect_wb("rnd.wbrd", ic + RD_LAT + 1, ref_mem[b]);
        end

        // WB abort: cyc drops while the read is in flight.
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3800_0040;
        settle();
        check("abort.en", 32'(bram_en), 32'd1);
        tick();
        wbs_cyc_i = 0; wbs_stb_i = 0;
        wait_ticks(RD_LAT + 5);
        check("abort.acks", 32'(wb_q.size()), 32'd0);
        wb_q.delete();
        wb_xfer("abort.next", 32'h3800_0044, 0, 4'hF, 32'h0, ic);
        expect_wb("abort.next", ic + RD_LAT + 1, ref_mem[17]);

        // 20-beat DMA stream with a WB read pending: cut at 16, WB in, DMA resumes.
        dma_q.delete(); gq.delete();
        grants = 0; wb_done = 0; wb_ic = -1; s_c = cyc_n;
        for (int t = 0; t < 80 && grants < 20; t++) begin
            dma_req = 1; dma_we = 0; dma_last = 0; dma_addr = 10'(10'h300 + grants);
            wb_on = (t >= 1) && !wb_done;
            wbs_cyc_i = wb_on; wbs_stb_i = wb_on; wbs_we_i = 0; wbs_adr_i = 32'h3800_0140;
            settle();
            if (dma_gnt) begin gq.push_back(cyc_n); grants++; end
            else if (bram_en) wb_ic = cyc_n;
            if (wbs_ack_o) wb_done = 1;
            tick();
        end
        dma_req = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
        wait_ticks(RD_LAT + 3);
        check("maxb.grants", 32'(grants), 32'd20);
        if (gq.size() == 20) begin
            check("maxb.beat16_cyc", 32'(gq[15]), 32'(s_c + 15));
            check("maxb.resume_cyc", 32'(gq[16]), 32'(s_c + 16 + RD_LAT + 1));
        end
        check("maxb.wb_issue_cyc", 32'(wb_ic), 32'(s_c + 16));
        expect_wb("maxb.wb", s_c + 16 + RD_LAT + 1, ref_mem[10'h050]);
        check("maxb.beats", 32'(dma_q.size()), 32'd20);
        if (dma_q.size() == 20 && gq.size() == 20)
            for (int k = 0; k < 20; k++) begin
                check("maxb.rv_cyc", 32'(dma_q[k].c), 32'(gq[k] + RD_LAT + 1));
                check("maxb.rdata", dma_q[k].d, ref_mem[10'(10'h300 + k)]);
            end
        dma_q.delete();

        // Reset with three DMA reads in flight.
        dma_burst("rst", 10'h080, 3, 0, fc);
        rstn = 0;
        tick();
        rstn = 1;
        settle();
        check_reset_outputs("midrst");
        wait_ticks(RD_LAT + 5);
        check("midrst.rvalids", 32'(dma_q.size()), 32'd0);
        check("midrst.acks", 32'(wb_q.size()), 32'd0);
        dma_q.delete(); wb_q.delete();

        // Contention: first after reset goes to WB; the next one tests the arbitration mode.
        x = 10'h3A0; y = 10'h3B0; d = $urandom; d2 = $urandom;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
        wbs_adr_i = {20'h38000, x, 2'b00}; wbs_dat_i = d;
        dma_req = 1; dma_we = 0; dma_addr = y; dma_last = 1;
        settle();
        check("arb1.gnt", 32'(dma_gnt), 32'd0);
        check("arb1.addr", 32'(bram_addr), 32'(x));
        check("arb1.we", 32'(bram_we), 32'hF);
        ref_mem[x] = d;
        tick();
        dma_req = 0;
        settle();
        check("arb1.ack", 32'(wbs_ack_o), 32'd1);
        check("arb1.idle_en", 32'(bram_en), 32'd0);
        tick();
        wbs_adr_i = {20'h38000, 10'(x + 1), 2'b00}; wbs_dat_i = d2;
        dma_req = 1;
        settle();
        ref_mem[10'(x + 1)] = d2;
`ifdef ARB_FIXED_PRIO_EN
        check("arb2.gnt", 32'(dma_gnt), 32'd0);
        check("arb2.addr", 32'(bram_addr), 32'(10'(x + 1)));
        tick(); settle();
        check("arb2.ack", 32'(wbs_ack_o), 32'd1);
        check("arb3.gnt", 32'(dma_gnt), 32'd1);
        check("arb3.addr", 32'(bram_addr), 32'(y));
        fc = cyc_n;
        tick();
        dma_req = 0; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
`else
        check("arb2.gnt", 32'(dma_gnt), 32'd1);
        check("arb2.addr", 32'(bram_addr), 32'(y));
        fc = cyc_n;
        tick();
        dma_req = 0;
        settle();
        check("arb3.gnt", 32'(dma_gnt), 32'd0);
        check("arb3.addr", 32'(bram_addr), 32'(10'(x + 1)));
        check("arb3.we", 32'(bram_we), 32'hF);
        tick(); settle();
        check("arb3.ack", 32'(wbs_ack_o), 32'd1);
        tick();
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
`endif
        wait_ticks(RD_LAT + 3);
        expect_dma("arb.dma", y, 1, fc);
        wb_q.delete();
        wb_xfer("arb.rdback", {20'h38000, 10'(x + 1), 2'b00}, 0, 4'hF, 32'h0, ic);
        expect_wb("arb.rdback", ic + RD_LAT + 1, d2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mprjram_arbiter.md
Name: mprjram_arbiter

Overview:
Arbitrates the single-port user-project BRAM (mprjram, 0x3800_0000) between two requesters: the management core's Wishbone slave path (instruction fetch and data for code linked into mprjram) and the accelerator DMA port (FIR/MM/qsort engines).
- Pipelines BRAM reads with source tagging, so read data from one owner can still be returning while the other owner issues.
- Sits between the Wishbone decode in the user project wrapper and the BRAM macro.

Parameters:
ADDR_W, 10, BRAM word-address width (1024 x 32-bit words = 4 KB)
RD_LAT, 10, BRAM read latency in cycles: bram_rdata is valid RD_LAT cycles after the bram_en cycle
MAX_BURST, 16, maximum DMA beats per grant before a forced re-arbitration
BASE_HI, 8'h38, value wbs_adr_i[31:24] must match for a Wishbone hit

Ports:
wb_clk_i  in  1  clock
wb_rstn_i  in  1  synchronous active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  4  Wishbone byte selects
wbs_adr_i  in  32  Wishbone byte address
wbs_dat_i  in  32  Wishbone write data
wbs_ack_o  out  1  Wishbone ack, one-cycle pulse
wbs_dat_o  out  32  Wishbone read data
dma_req  in  1  DMA beat request
dma_we  in  1  DMA write (all 4 bytes)
dma_addr  in  ADDR_W  DMA word address
dma_wdata  in  32  DMA write data
dma_last  in  1  marks the final beat of a burst
dma_gnt  out  1  beat accepted this cycle
dma_rvalid  out  1  DMA read data valid, one-cycle pulse
dma_rdata  out  32  DMA read data
bram_en  out  1  BRAM access enable
bram_we  out  4  BRAM byte write enables
bram_addr  out  ADDR_W  BRAM word address
bram_wdata  out  32  BRAM write data
bram_rdata  in  32  BRAM read data

Behaviour:
Clock and reset:
- Single clock wb_clk_i.
- wb_rstn_i is synchronous and active-low.

Reset values:
- wbs_ack_o=0, wbs_dat_o=0, dma_gnt=0, dma_rvalid=0, dma_rdata=0, bram_en=0, bram_we=0.
- State = IDLE; tag pipeline cleared; beat count = 0.
- last_owner = DMA, so Wishbone wins the first contention.

Requests:
- wb_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==BASE_HI) & no Wishbone access outstanding.
- Word address = wbs_adr_i[ADDR_W+1:2].
- Wishbone requests that miss BASE_HI are ignored and never acked.

State machine (IDLE, WB_WAIT, DMA_BURST):
- IDLE, wb_hit only -> issue the WB access this cycle.
- IDLE, dma_req only -> enter DMA_BURST and issue the beat this cycle.
- IDLE, both -> round-robin: the requester that is not last_owner wins.
- WB issue, read: go to WB_WAIT; last_owner = WB.
- WB issue, write: bram_we = wbs_sel_i; ack next cycle; stay in IDLE; last_owner = WB.
- WB_WAIT: no new issue. Return to IDLE in the cycle the WB ack is driven.
- DMA_BURST: dma_gnt=1 (combinational) and one BRAM access in every cycle dma_req=1.
  - bram_we = 4'hF when dma_we=1.
  - Burst ends (-> IDLE, last_owner = DMA) after the granted beat with dma_last=1, or the MAX_BURST-th beat, or the first cycle dma_req=0.
  - A burst cut by MAX_BURST resumes only after re-arbitration.
- The BRAM address/data/we mux is combinational from the winning request; bram_en=0 when nothing is issued.

Read return path:
- A source tag (WB/DMA/none) is shifted through an RD_LAT-deep pipeline and sampled with bram_rdata.
- Output latency: registered wbs_ack_o/wbs_dat_o or dma_rvalid/dma_rdata assert RD_LAT+1 cycles after the issue cycle.
- DMA reads are fully pipelined at one per cycle and return in order.
- Return slots from a finished DMA burst may overlap a new WB issue; tags keep them separated.

Boundary conditions:
- WB abort: if wbs_cyc_i drops while a WB read is in flight, the data is discarded, no ack is driven, and the block returns to IDLE when the tag arrives.
- wbs_dat_o holds its last value between acks.
- Reset mid-operation: in-flight tags are cleared and no ack/rvalid is produced for accesses already issued.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: Wishbone has fixed priority in IDLE. DMA wins only when wb_hit=0; MAX_BURST still bounds DMA bursts so the CPU is never starved beyond MAX_BURST cycles.
- Undefined: round-robin as above.

Test Plan:
- Reset, then WB read at 0x3800_0010 with BRAM word 4 = 0xDEADBEEF -> bram_en with addr 4 in the issue cycle; wbs_ack_o pulses 11 cycles later with wbs_dat_o = 0xDEADBEEF.
- WB write 0x3800_0008, data 0x12345678, sel 4'b0011 -> bram_we = 0011 and addr 2 in the issue cycle; ack 1 cycle later; a subsequent read returns the modified low half.
- DMA 4-beat read burst at addr 0x100..0x103, dma_last on beat 4 -> dma_gnt high 4 consecutive cycles; dma_rvalid high 4 consecutive cycles starting 11 cycles after the first grant, data in order.
- WB and DMA both request in the first cycle after reset -> WB wins; at the next IDLE with both requesting -> DMA wins (alternation). With ARB_FIXED_PRIO_EN -> WB wins both times.
- DMA holds dma_req for 20 beats with no dma_last while WB is pending -> burst cut after 16 grants, WB issues next, then DMA resumes.
- Assert wb_rstn_i=0 for one cycle while 3 DMA reads are in flight -> no dma_rvalid afterward; all outputs at reset values the next cycle.
